// File: rtl/i2s_capture_sequencer_pkg.sv
// Shared types and constants for the I2S capture sequencer slice.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } seq_state_t;

  localparam int BITS_PER_WORD_DEFAULT = 32;
  localparam int FRAME_WIDTH           = 2 * BITS_PER_WORD_DEFAULT;

  // One stereo frame carries both channel words side by side.
  function automatic int frame_width(input int bits_per_word);
    return 2 * bits_per_word;
  endfunction

endpackage

// File: rtl/i2s_capture_sequencer_if.sv
// Valid/ready stream carrying captured stereo frames to downstream DSP/DMA logic.
interface i2s_capture_sequencer_if
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = FRAME_WIDTH
);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/i2s_capture_sequencer_sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head word and full/empty flags.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign push_ok     = push && !full;
  assign pop_ok      = pop && !empty;
  assign rd_ptr_next = pop_ok ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // The head register bypasses the write when the slot being written becomes the new head.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr  <= rd_ptr_next;
      count   <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
      rd_data <= (push_ok && (wr_ptr == rd_ptr_next)) ? wr_data : mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/i2s_capture_sequencer.sv
// Bounded I2S capture: hold the controller in reset, skip warm-up frames, buffer N frames, drain.
module i2s_capture_sequencer
  import i2s_pkg::*;
#(
  parameter int BITS_PER_WORD = 32,
  parameter int FIFO_DEPTH    = 8,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [COUNT_WIDTH-1:0]   warmup_frames,
  input  logic [COUNT_WIDTH-1:0]   capture_frames,
  output logic                     i2s_reset,
  input  logic                     frame_valid,
  input  logic [BITS_PER_WORD-1:0] frame_0,
  input  logic [BITS_PER_WORD-1:0] frame_1,
  i2s_capture_sequencer_if.master  stream,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [COUNT_WIDTH-1:0]   frames_captured
);

  localparam int FW = frame_width(BITS_PER_WORD);
  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  seq_state_t             state;
  seq_state_t             state_next;
  logic [COUNT_WIDTH-1:0] warm_target;
  logic [COUNT_WIDTH-1:0] cap_target;
  logic [COUNT_WIDTH-1:0] warm_count;
  logic [COUNT_WIDTH-1:0] cap_count;
  logic                   accept_start;
  logic                   strobe_ok;
  logic                   push_req;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [FW-1:0]          fifo_data;

  assign accept_start = (state == IDLE) && start;
  assign strobe_ok    = frame_valid && !stop;
  assign push_req     = (state == CAPTURE) && strobe_ok;
  assign fifo_pop     = stream.m_valid && stream.m_ready;

  assign stream.m_valid = !fifo_empty;
  assign stream.m_data  = fifo_data;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push_req),
    .wr_data ({frame_1, frame_0}),
    .pop     (fifo_pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A zero-length capture never leaves IDLE; stop only matters while the controller runs.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start && (capture_frames != '0)) begin
          state_next = (warmup_frames == '0) ? CAPTURE : WARMUP;
        end
      end
      WARMUP: begin
        if (stop) begin
          state_next = DRAIN;
        end else if (frame_valid && (warm_count + ONE == warm_target)) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (stop) begin
          state_next = DRAIN;
        end else if (frame_valid && (cap_count + ONE == cap_target)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    i2s_reset = (state == IDLE) || (state == DRAIN);
    busy      = (state != IDLE);
  end

  // A dropped frame still advances the capture count so capture time stays bounded.
  always_ff @(posedge clock) begin
    if (reset) begin
      warm_target     <= '0;
      cap_target      <= '0;
      warm_count      <= '0;
      cap_count       <= '0;
      done            <= 1'b0;
      overflow        <= 1'b0;
      frames_captured <= '0;
    end else begin
      done <= (accept_start && (capture_frames == '0)) ||
              ((state == DRAIN) && fifo_empty);
      if (accept_start) begin
        warm_target     <= warmup_frames;
        cap_target      <= capture_frames;
        warm_count      <= '0;
        cap_count       <= '0;
        overflow        <= 1'b0;
        frames_captured <= '0;
      end
      if ((state == WARMUP) && strobe_ok) begin
        warm_count <= warm_count + ONE;
      end
      if (push_req) begin
        cap_count <= cap_count + ONE;
        if (fifo_full) begin
          overflow <= 1'b1;
        end else begin
          frames_captured <= frames_captured + ONE;
        end
      end
    end
  end

endmodule
